// File: rtl/three_way_block_packer.sv
// Packs three 32-bit stream words into one 96-bit block (first word in [95:64]), padding blocks closed early by tlast.
// Block valid 1 cycle after its closing word; input stalls while a held block is not drained; byte swap via THREE_WAY_PACK_BSWAP_EN.
module three_way_block_packer #(
  parameter logic [31:0] PAD_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [95:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [1:0]  m_axis_tcount
);

  typedef enum logic [1:0] {W0, W1, W2} state_t;

  state_t      state_q, state_d;
  logic        rst_q;
  logic [31:0] slot0_q, slot0_d;
  logic [31:0] slot1_q, slot1_d;
  logic [95:0] out_dat_q, out_dat_d;
  logic        out_vld_q, out_vld_d;
  logic        out_last_q, out_last_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic        s_fire;
  logic [31:0] word;

  function automatic logic [31:0] prep_word(input logic [31:0] w);
`ifdef THREE_WAY_PACK_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Stalls whenever the output register is occupied and not draining this cycle, regardless of state.
  assign s_axis_tready = !rst_q && (!out_vld_q || m_axis_tready);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign word          = prep_word(s_axis_tdata);

  assign m_axis_tdata  = out_dat_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tcount = out_cnt_q;

  always_comb begin
    state_d    = state_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_cnt_d  = out_cnt_q;

    if (out_vld_q && m_axis_tready) begin
      out_vld_d = 1'b0;
    end

    // A new emit overrides the drain above, so back-to-back blocks keep valid high.
    if (s_fire) begin
      case (state_q)
        W0: begin
          if (s_axis_tlast) begin
            out_dat_d  = {word, PAD_WORD, PAD_WORD};
            out_vld_d  = 1'b1;
            out_last_d = 1'b1;
            out_cnt_d  = 2'd1;
            state_d    = W0;
          end else begin
            slot0_d = word;
            state_d = W1;
          end
        end
        W1: begin
          if (s_axis_tlast) begin
            out_dat_d  = {slot0_q, word, PAD_WORD};
            out_vld_d  = 1'b1;
            out_last_d = 1'b1;
            out_cnt_d  = 2'd2;
            state_d    = W0;
          end else begin
            slot1_d = word;
            state_d = W2;
          end
        end
        W2: begin
          out_dat_d  = {slot0_q, slot1_q, word};
          out_vld_d  = 1'b1;
          out_last_d = s_axis_tlast;
          out_cnt_d  = 2'd3;
          state_d    = W0;
        end
        default: state_d = W0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      state_q    <= W0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      out_dat_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_cnt_q  <= 2'd0;
    end else begin
      rst_q      <= 1'b0;
      state_q    <= state_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_three_way_block_packer.sv
// Directed bench for three_way_block_packer: reset, full/partial blocks, backpressure, streaming, mid-block reset, byte swap.
module tb_three_way_block_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_dat = '0;
  logic        s_vld = 1'b0;
  logic        s_rdy;
  logic        s_last = 1'b0;
  logic [95:0] m_dat;
  logic        m_vld;
  logic        m_rdy = 1'b1;
  logic        m_last;
  logic [1:0]  m_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  three_way_block_packer #(.PAD_WORD(32'h00000000)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_dat),
    .s_axis_tvalid (s_vld),
    .s_axis_tready (s_rdy),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (m_dat),
    .m_axis_tvalid (m_vld),
    .m_axis_tready (m_rdy),
    .m_axis_tlast  (m_last),
    .m_axis_tcount (m_cnt)
  );

  function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef THREE_WAY_PACK_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Offers one word from posedge+1 and returns at posedge+1 after it is accepted.
  task automatic put(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_vld = 1'b1; s_dat = d; s_last = l;
    @(negedge clk);
    while (!s_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL put_timeout word=%h ready=%b required 1", d, s_rdy);
    end
    @(posedge clk); #1;
    s_vld = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_vld = 1'b0; m_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b required 0", s_rdy);
    end
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== 100'd0) begin
      errors++; $display("FAIL reset_outputs got vld=%b last=%b cnt=%0d dat=%h required all 0", m_vld, m_last, m_cnt, m_dat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after got=%b required 1", s_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_block;
    logic [95:0] e;
    e = {exp_w(32'hFEDCBA98), exp_w(32'h76543210), exp_w(32'hBBBBAAAA)};
    m_rdy = 1'b1;
    put(32'hFEDCBA98, 1'b0);
    @(negedge clk);
    checks++;
    if (m_vld !== 1'b0) begin
      errors++; $display("FAIL full_early_valid got=%b required 0", m_vld);
    end
    @(posedge clk); #1;
    put(32'h76543210, 1'b0);
    put(32'hBBBBAAAA, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b1, 2'd3, e}) begin
      errors++; $display("FAIL full_block got vld=%b last=%b cnt=%0d dat=%h required 1 1 3 %h", m_vld, m_last, m_cnt, m_dat, e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_vld !== 1'b0) begin
      errors++; $display("FAIL full_one_cycle got vld=%b required 0", m_vld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial;
    logic [95:0] e;
    m_rdy = 1'b1;
    put(32'h11112222, 1'b1);
    e = {exp_w(32'h11112222), 64'd0};
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b1, 2'd1, e}) begin
      errors++; $display("FAIL partial_one got vld=%b last=%b cnt=%0d dat=%h required 1 1 1 %h", m_vld, m_last, m_cnt, m_dat, e);
    end
    @(posedge clk); #1;
    put(32'h0000000A, 1'b0);
    put(32'h0000000B, 1'b1);
    e = {exp_w(32'h0000000A), exp_w(32'h0000000B), 32'd0};
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b1, 2'd2, e}) begin
      errors++; $display("FAIL partial_two got vld=%b last=%b cnt=%0d dat=%h required 1 1 2 %h", m_vld, m_last, m_cnt, m_dat, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [95:0] e1, e2;
    e1 = {exp_w(32'h100), exp_w(32'h200), exp_w(32'h300)};
    e2 = {exp_w(32'h600), 64'd0};
    m_rdy = 1'b0;
    put(32'h100, 1'b0);
    put(32'h200, 1'b0);
    put(32'h300, 1'b0);
    s_vld = 1'b1; s_dat = 32'h600; s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({s_rdy, m_vld, m_cnt, m_dat} !== {1'b0, 1'b1, 2'd3, e1}) begin
        errors++; $display("FAIL hold_cycle%0d got rdy=%b vld=%b cnt=%0d dat=%h required 0 1 3 %h", c, s_rdy, m_vld, m_cnt, m_dat, e1);
      end
      @(posedge clk); #1;
    end
    m_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_rdy, m_vld} !== 2'b11) begin
      errors++; $display("FAIL drain_ready got rdy=%b vld=%b required 1 1", s_rdy, m_vld);
    end
    @(posedge clk); #1;
    s_vld = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b1, 2'd1, e2}) begin
      errors++; $display("FAIL reload_block got vld=%b last=%b cnt=%0d dat=%h required 1 1 1 %h", m_vld, m_last, m_cnt, m_dat, e2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_vld !== 1'b0) begin
      errors++; $display("FAIL reload_drained got vld=%b required 0", m_vld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming;
    logic [95:0] e;
    m_rdy = 1'b1;
    s_last = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c < 9) begin
        s_vld = 1'b1; s_dat = 32'(c + 1);
      end else begin
        s_vld = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (c < 9 && s_rdy !== 1'b1) begin
        errors++; $display("FAIL stream_ready cycle%0d got=%b required 1", c, s_rdy);
      end
      checks++;
      if (c == 3 || c == 6 || c == 9) begin
        e = {exp_w(32'(c - 2)), exp_w(32'(c - 1)), exp_w(32'(c))};
        if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b0, 2'd3, e}) begin
          errors++; $display("FAIL stream_block cycle%0d got vld=%b last=%b cnt=%0d dat=%h required 1 0 3 %h", c, m_vld, m_last, m_cnt, m_dat, e);
        end
      end else if (m_vld !== 1'b0) begin
        errors++; $display("FAIL stream_gap cycle%0d got vld=%b required 0", c, m_vld);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    logic [95:0] e;
    e = {exp_w(32'hC), exp_w(32'hD), exp_w(32'hE)};
    m_rdy = 1'b1;
    put(32'h77, 1'b0);
    put(32'h88, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_rdy, m_vld, m_dat} !== {1'b0, 1'b0, 96'd0}) begin
      errors++; $display("FAIL midreset_state got rdy=%b vld=%b dat=%h required 0 0 0", s_rdy, m_vld, m_dat);
    end
    @(posedge clk); #1;
    put(32'hC, 1'b0);
    put(32'hD, 1'b0);
    @(negedge clk);
    checks++;
    if (m_vld !== 1'b0) begin
      errors++; $display("FAIL midreset_no_stale got vld=%b dat=%h required vld 0", m_vld, m_dat);
    end
    @(posedge clk); #1;
    put(32'hE, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b1, 2'd3, e}) begin
      errors++; $display("FAIL midreset_block got vld=%b last=%b cnt=%0d dat=%h required 1 1 3 %h", m_vld, m_last, m_cnt, m_dat, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bswap;
    logic [95:0] e;
`ifdef THREE_WAY_PACK_BSWAP_EN
    e = 96'h674523016745230167452301;
`else
    e = 96'h012345670123456701234567;
`endif
    m_rdy = 1'b1;
    put(32'h01234567, 1'b0);
    put(32'h01234567, 1'b0);
    put(32'h01234567, 1'b1);
    @(negedge clk);
    checks++;
    if ({m_vld, m_last, m_cnt, m_dat} !== {1'b1, 1'b1, 2'd3, e}) begin
      errors++; $display("FAIL bswap_block got vld=%b last=%b cnt=%0d dat=%h required 1 1 3 %h", m_vld, m_last, m_cnt, m_dat, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_full_block;
    test_partial;
    test_back_to_back;
    test_streaming;
    test_reset_mid;
    test_bswap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/three_way_block_packer.md
Name: three_way_block_packer

Overview:
Upstream feeder for the 3-Way cipher pipeline.
- Accepts a 32-bit AXI-Stream word stream and packs every 3 words into one 96-bit block.
- Presents each block on a 96-bit AXI-Stream master that connects directly to the cipher's s_axis_* slave port.
- Pads short final blocks on tlast and reports how many words in the block are valid.

Parameters:
PAD_WORD, 32'h00000000, fill value for unused word slots of a block closed early by tlast

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
s_axis_tdata  input  32  input word
s_axis_tvalid  input  1  input word valid
s_axis_tready  output  1  packer can accept a word
s_axis_tlast  input  1  last word of message
m_axis_tdata  output  96  packed block; first word of block in [95:64], second in [63:32], third in [31:0]
m_axis_tvalid  output  1  block valid
m_axis_tready  input  1  downstream (cipher) accepts block
m_axis_tlast  output  1  block contains the message's last word
m_axis_tcount  output  2  valid words in block: 1, 2 or 3 (never 0 while tvalid=1)

Behaviour:
- Reset (rst=1 at clk edge), all outputs and state cleared:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tcount=0.
  - Word index = 0; assembly register = 0.
  - s_axis_tready=0 during the reset cycle and 1 on the first cycle after reset.
  - Reset mid-block discards the partial block and any held output block; nothing is emitted.
- Storage: one assembly register (2 x 32-bit slots for words 0,1) plus one output register (96-bit + tlast + tcount).
- Word-index FSM, advancing on s_axis_tvalid && s_axis_tready:
  - W0: store word in slot0 -> W1. If tlast: emit {w, PAD, PAD}, count=1 -> W0.
  - W1: store word in slot1 -> W2. If tlast: emit {slot0, w, PAD}, count=2 -> W0.
  - W2: emit {slot0, slot1, w}, count=3, tlast = s_axis_tlast -> W0.
- Emit means the output register loads at that edge, and m_axis_tvalid=1 from the next cycle.
  - Latency: block valid 1 cycle after the closing word is accepted.
- Output hold:
  - m_axis_tvalid, tdata, tlast and tcount stay stable until m_axis_tvalid && m_axis_tready.
  - On that transfer edge, m_axis_tvalid clears unless a new block is emitted in the same edge; in that case the register reloads and valid stays 1.
- Ready rule: s_axis_tready = !rst_q && (!m_axis_tvalid || m_axis_tready), where rst_q is a register that is 1 during reset.
  - Combinational path from m_axis_tready to s_axis_tready is permitted.
  - The stall applies in every FSM state; it is deliberately conservative.
- Throughput: 1 word/cycle sustained with m_axis_tready=1, i.e. 1 full block every 3 cycles.
- Simultaneous events:
  - Output drain and closing-word accept in the same cycle -> both occur; no bubble, no loss.
  - s_axis_tvalid=0 mid-block -> FSM holds; no timeout, no flush.
- tlast on the 3rd word produces count=3, tlast=1; no extra empty block.
- Words on s_axis_tdata while tready=0 are ignored; the upstream must hold them, per AXI.

Optional Feature:
Macro THREE_WAY_PACK_BSWAP_EN.
- Defined: every accepted input word is byte-reversed before storage (bytes [7:0],[15:8],[23:16],[31:24] -> [31:24],[23:16],[15:8],[7:0]). PAD_WORD is not swapped.
- Undefined: words are stored as received.
- Timing, handshake and count are identical in both builds.

Test Plan:
- Full block, no backpressure: words 32'hFEDCBA98, 32'h76543210, 32'hBBBBAAAA (tlast on 3rd), m_axis_tready=1 -> one cycle after 3rd accept, m_axis_tdata=96'hFEDCBA9876543210BBBBAAAA, tlast=1, tcount=3, valid for exactly 1 cycle.
- Partial block: single word 32'h11112222 with tlast, PAD_WORD=0 -> m_axis_tdata=96'h111122220000000000000000, tlast=1, tcount=1. Then 2 words 32'hA, 32'hB with tlast -> 96'h0000000A0000000B00000000, tcount=2.
- Backpressure: m_axis_tready=0 with a block held -> s_axis_tready=0, tdata stable for 5 cycles. Raise m_axis_tready while the next closing word is offered -> held block transfers and new block loads on the same edge, with no gap in m_axis_tvalid.
- Streaming: 9 words 1..9, no tlast, both sides always valid/ready -> blocks {1,2,3}, {4,5,6}, {7,8,9}, each tcount=3, tlast=0, spaced 3 cycles apart.
- Reset mid-operation: accept 2 words, assert rst 1 cycle, then send 3 words 32'hC, 32'hD, 32'hE -> only block 96'h0000000C0000000D0000000E appears; pre-reset words are never output.
- BSWAP build: word 32'h01234567 ×3, tlast -> m_axis_tdata=96'h674523016745230167452301. Without the macro -> 96'h012345670123456701234567.
